// File: rtl/doorlock_param_core.sv
// doorlock_param_core: keypad door-lock controller with retry alarm and authenticated password change.
// Optional entry inactivity timeout is compiled in when DOORLOCK_TIMEOUT_EN is defined.
module doorlock_param_core #(
  parameter int                  PW_LEN         = 4,
  parameter logic [PW_LEN*4-1:0] DEFAULT_PW     = 16'h1234,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  ALARM_CYCLES   = 16,
  parameter int                  TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       star,
  input  logic       sharp,
  input  logic [9:0] number,
  output logic       open,
  output logic       alarm,
  output logic       mode_active,
  output logic       mode_set,
  output logic [3:0] fail_cnt
);
  localparam int PW_W    = PW_LEN * 4;
  localparam int DC_W    = $clog2(PW_LEN + 1);
  localparam int HOLD_MX = (OPEN_CYCLES > ALARM_CYCLES) ? OPEN_CYCLES : ALARM_CYCLES;
  localparam int CNT_MX  = (HOLD_MX > TIMEOUT_CYCLES) ? HOLD_MX : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTER, S_AUTH, S_NEW, S_OPEN, S_ALARM} state_t;

  state_t           state, state_n;
  logic [PW_W-1:0]  ent_buf, ent_buf_n, buf_shift, pw, pw_n;
  logic [DC_W-1:0]  dcnt, dcnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       fail_n, fail_inc, dig;
  logic             dig_vld, room, match;

  always_comb begin
    dig = '0;
    for (int i = 0; i < 10; i++) if (number[i]) dig = 4'(i);
  end

  assign dig_vld   = $onehot(number);
  assign room      = dcnt < DC_W'(PW_LEN);
  assign match     = (dcnt == DC_W'(PW_LEN)) && (ent_buf == pw);
  assign buf_shift = (ent_buf << 4) | PW_W'(dig);
  // failure count saturates; alarm entry clears it again on exit
  assign fail_inc  = (fail_cnt < 4'(MAX_FAIL)) ? fail_cnt + 4'd1 : fail_cnt;

  always_comb begin
    state_n   = state;
    ent_buf_n = ent_buf;
    dcnt_n    = dcnt;
    pw_n      = pw;
    fail_n    = fail_cnt;
    cnt_n     = '0;
    case (state)
      S_IDLE: begin
        if (star || sharp) begin
          state_n   = star ? S_ENTER : S_AUTH;
          ent_buf_n = '0;
          dcnt_n    = '0;
        end
      end
      S_ENTER, S_AUTH: begin
        if (star) begin
          ent_buf_n = '0;
          dcnt_n    = '0;
          if (state == S_AUTH) state_n = S_IDLE;
        end else if (sharp) begin
          ent_buf_n = '0;
          dcnt_n    = '0;
          if (match) begin
            fail_n  = '0;
            state_n = (state == S_ENTER) ? S_OPEN : S_NEW;
          end else begin
            fail_n  = fail_inc;
            state_n = (fail_inc == 4'(MAX_FAIL)) ? S_ALARM : S_IDLE;
          end
        end else if (dig_vld && room) begin
          ent_buf_n = buf_shift;
          dcnt_n    = dcnt + DC_W'(1);
        end
      end
      S_NEW: begin
        if (star || sharp) begin
          // a short new password is silently discarded
          if (!star && dcnt == DC_W'(PW_LEN)) pw_n = ent_buf;
          state_n   = S_IDLE;
          ent_buf_n = '0;
          dcnt_n    = '0;
        end else if (dig_vld && room) begin
          ent_buf_n = buf_shift;
          dcnt_n    = dcnt + DC_W'(1);
        end
      end
      S_OPEN: begin
        if (cnt == CNT_W'(OPEN_CYCLES - 1)) state_n = S_IDLE;
        else cnt_n = cnt + CNT_W'(1);
      end
      S_ALARM: begin
        if (cnt == CNT_W'(ALARM_CYCLES - 1)) begin
          state_n = S_IDLE;
          fail_n  = '0;
        end else cnt_n = cnt + CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
`ifdef DOORLOCK_TIMEOUT_EN
    // hold counter doubles as the inactivity timer while waiting for keys
    if ((state == S_ENTER || state == S_AUTH || state == S_NEW) && !(star || sharp || dig_vld)) begin
      if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_n   = S_IDLE;
        ent_buf_n = '0;
        dcnt_n    = '0;
      end else cnt_n = cnt + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      ent_buf     <= '0;
      dcnt        <= '0;
      pw          <= DEFAULT_PW;
      fail_cnt    <= '0;
      cnt         <= '0;
      open        <= 1'b0;
      alarm       <= 1'b0;
      mode_active <= 1'b0;
      mode_set    <= 1'b0;
    end else begin
      state       <= state_n;
      ent_buf     <= ent_buf_n;
      dcnt        <= dcnt_n;
      pw          <= pw_n;
      fail_cnt    <= fail_n;
      cnt         <= cnt_n;
      open        <= (state_n == S_OPEN);
      alarm       <= (state_n == S_ALARM);
      mode_active <= (state_n == S_ENTER) || (state_n == S_AUTH);
      mode_set    <= (state_n == S_NEW);
    end
  end
endmodule

// File: tb/tb_doorlock_param_core.sv
// Testbench for doorlock_param_core: directed scenarios plus randomized keys against a queue-based model.
module tb_doorlock_param_core;
  localparam int PW_LEN = 4, MAX_FAIL = 3, OPEN_C = 8, ALARM_C = 16, TMO_C = 32;
  localparam int M_IDLE = 0, M_ENTER = 1, M_AUTH = 2, M_NEW = 3, M_OPEN = 4, M_ALARM = 5;

  logic       clk = 1'b0, n_rst = 1'b1, star = 1'b0, sharp = 1'b0;
  logic [9:0] number = '0;
  logic       open, alarm, mode_active, mode_set;
  logic [3:0] fail_cnt;
  int         checks = 0, errors = 0;

  // behavioural model: mode, entered digits, stored password digits, remaining hold cycles
  int m_mode, m_fail, m_left, m_idle;
  int m_q[$];
  int m_pw[$];

  doorlock_param_core #(
    .PW_LEN(PW_LEN), .DEFAULT_PW(16'h1234), .MAX_FAIL(MAX_FAIL),
    .OPEN_CYCLES(OPEN_C), .ALARM_CYCLES(ALARM_C), .TIMEOUT_CYCLES(TMO_C)
  ) dut (
    .clk(clk), .n_rst(n_rst), .star(star), .sharp(sharp), .number(number),
    .open(open), .alarm(alarm), .mode_active(mode_active), .mode_set(mode_set),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE; m_fail = 0; m_left = 0; m_idle = 0;
    m_q.delete();
    m_pw = '{1, 2, 3, 4};
  endtask

  function automatic bit entry_ok();
    if (m_q.size() != m_pw.size()) return 1'b0;
    foreach (m_q[i]) if (m_q[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit s, input bit h, input logic [9:0] n);
    bit dv;
    int d;
    dv = ($countones(n) == 1);
    d = 0;
    for (int i = 0; i < 10; i++) if (n[i]) d = i;
    case (m_mode)
      M_OPEN:  begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
      M_ALARM: begin m_left--; if (m_left == 0) begin m_mode = M_IDLE; m_fail = 0; end end
      M_IDLE: begin
        if (s) m_mode = M_ENTER; else if (h) m_mode = M_AUTH;
        m_q.delete(); m_idle = 0;
      end
      default: begin
        if (s) begin
          m_q.delete();
          if (m_mode != M_ENTER) m_mode = M_IDLE;
        end else if (h) begin
          if (m_mode == M_NEW) begin
            if (m_q.size() == PW_LEN) m_pw = m_q;
            m_mode = M_IDLE;
          end else if (entry_ok()) begin
            m_fail = 0;
            if (m_mode == M_ENTER) begin m_mode = M_OPEN; m_left = OPEN_C; end
            else m_mode = M_NEW;
          end else begin
            if (m_fail < MAX_FAIL) m_fail++;
            if (m_fail == MAX_FAIL) begin m_mode = M_ALARM; m_left = ALARM_C; end
            else m_mode = M_IDLE;
          end
          m_q.delete();
        end else if (dv && m_q.size() < PW_LEN) m_q.push_back(d);
`ifdef DOORLOCK_TIMEOUT_EN
        if (s || h || dv) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TMO_C) begin m_mode = M_IDLE; m_q.delete(); end
        end
`endif
      end
    endcase
  endtask

  // called at a falling edge; returns at the next falling edge with inputs released
  task automatic press(input bit s, input bit h, input logic [9:0] n);
    star = s; sharp = h; number = n;
    @(posedge clk);
    model_step(s, h, n);
    @(negedge clk);
    star = 1'b0; sharp = 1'b0; number = '0;
  endtask

  task automatic key(input int d);
    press(1'b0, 1'b0, 10'(1) << d);
  endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) press(1'b0, 1'b0, 10'h000);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; star = 1'b0; sharp = 1'b0; number = '0;
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({open, alarm, mode_active, mode_set, fail_cnt} !== 8'h00) begin
      errors++; $display("FAIL reset_hold got %b exp 00000000", {open, alarm, mode_active, mode_set, fail_cnt});
    end
    @(negedge clk); n_rst = 1'b1; model_reset();
    idle(2);
    checks++;
    if ({open, alarm, mode_active, mode_set, fail_cnt} !== 8'h00) begin
      errors++; $display("FAIL reset_idle got %b exp 00000000", {open, alarm, mode_active, mode_set, fail_cnt});
    end
  endtask

  task automatic test_open();
    press(1'b1, 1'b0, 10'h000);
    checks++;
    if (mode_active !== 1'b1) begin errors++; $display("FAIL open_mode_active got %b exp 1", mode_active); end
    keys4(1, 2, 3, 4);
    press(1'b0, 1'b1, 10'h000);
    for (int i = 0; i < OPEN_C + 1; i++) begin
      checks++;
      if (open !== (i < OPEN_C)) begin errors++; $display("FAIL open_hold cyc %0d got %b exp %b", i, open, i < OPEN_C); end
      idle(1);
    end
    checks++;
    if (fail_cnt !== 4'd0) begin errors++; $display("FAIL open_fail_cnt got %0d exp 0", fail_cnt); end
  endtask

  task automatic test_alarm();
    for (int k = 1; k <= MAX_FAIL; k++) begin
      press(1'b1, 1'b0, 10'h000); keys4(9, 9, 9, 9); press(1'b0, 1'b1, 10'h000);
      checks++;
      if (fail_cnt !== 4'(k)) begin errors++; $display("FAIL alarm_fail_cnt try %0d got %0d exp %0d", k, fail_cnt, k); end
      if (k < MAX_FAIL) begin
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_early try %0d got %b exp 0", k, alarm); end
      end
    end
    for (int i = 0; i < ALARM_C + 1; i++) begin
      checks++;
      if (alarm !== (i < ALARM_C)) begin errors++; $display("FAIL alarm_hold cyc %0d got %b exp %b", i, alarm, i < ALARM_C); end
      idle(1);
    end
    checks++;
    if (fail_cnt !== 4'd0) begin errors++; $display("FAIL alarm_exit_fail_cnt got %0d exp 0", fail_cnt); end
  endtask

  task automatic test_change_pw();
    press(1'b0, 1'b1, 10'h000);
    checks++;
    if (mode_active !== 1'b1) begin errors++; $display("FAIL chg_auth got %b exp 1", mode_active); end
    keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
    checks++;
    if ({mode_active, mode_set} !== 2'b01) begin errors++; $display("FAIL chg_new got %b exp 01", {mode_active, mode_set}); end
    keys4(5, 6, 7, 8); press(1'b0, 1'b1, 10'h000);
    checks++;
    if (mode_set !== 1'b0) begin errors++; $display("FAIL chg_store got %b exp 0", mode_set); end
    press(1'b1, 1'b0, 10'h000); keys4(5, 6, 7, 8); press(1'b0, 1'b1, 10'h000);
    checks++;
    if (open !== 1'b1) begin errors++; $display("FAIL chg_new_pw_open got %b exp 1", open); end
    idle(OPEN_C);
    press(1'b1, 1'b0, 10'h000); keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
    checks++;
    if ({open, fail_cnt} !== 5'b0_0001) begin errors++; $display("FAIL chg_old_pw got %b exp 00001", {open, fail_cnt}); end
    press(1'b0, 1'b1, 10'h000); keys4(5, 6, 7, 8); press(1'b0, 1'b1, 10'h000);
    checks++;
    if ({mode_set, fail_cnt} !== 5'b1_0000) begin errors++; $display("FAIL chg_reauth got %b exp 10000", {mode_set, fail_cnt}); end
    keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
  endtask

  task automatic test_short_priority();
    press(1'b1, 1'b0, 10'h000); key(1); key(2); key(3); press(1'b0, 1'b1, 10'h000);
    checks++;
    if ({open, mode_active, fail_cnt} !== 6'b00_0001) begin errors++; $display("FAIL short_entry got %b exp 000001", {open, mode_active, fail_cnt}); end
    press(1'b1, 1'b1, 10'h000);
    checks++;
    if ({mode_active, mode_set} !== 2'b10) begin errors++; $display("FAIL star_wins got %b exp 10", {mode_active, mode_set}); end
    keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
    checks++;
    if ({open, mode_set, fail_cnt} !== 6'b10_0000) begin errors++; $display("FAIL star_wins_open got %b exp 100000", {open, mode_set, fail_cnt}); end
    idle(OPEN_C);
    checks++;
    if (open !== 1'b0) begin errors++; $display("FAIL short_open_end got %b exp 0", open); end
  endtask

  task automatic test_invalid_digit();
    press(1'b1, 1'b0, 10'h000); key(1);
    press(1'b0, 1'b0, 10'b0000000011); press(1'b0, 1'b0, 10'h000);
    key(2); key(3); key(4); key(5);
    press(1'b0, 1'b1, 10'h000);
    checks++;
    if (open !== 1'b1) begin errors++; $display("FAIL invalid_digit_open got %b exp 1", open); end
    idle(OPEN_C);
  endtask

  task automatic test_timeout();
    bit exp_active;
    press(1'b1, 1'b0, 10'h000); key(1);
    idle(TMO_C - 1);
    checks++;
    if (mode_active !== 1'b1) begin errors++; $display("FAIL timeout_early got %b exp 1", mode_active); end
    idle(1);
`ifdef DOORLOCK_TIMEOUT_EN
    exp_active = 1'b0;
`else
    exp_active = 1'b1;
`endif
    checks++;
    if ({mode_active, fail_cnt} !== {exp_active, 4'd0}) begin
      errors++; $display("FAIL timeout_expire got %b exp %b", {mode_active, fail_cnt}, {exp_active, 4'd0});
    end
  endtask

  task automatic test_random();
    bit s, h;
    logic [9:0] n;
    logic [7:0] got, exp;
    int r, nd;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      s = (r < 6); h = (r >= 6 && r < 14); n = '0;
      if (r < 3) n = 10'(1) << $urandom_range(0, 9);
      else if (r >= 14 && r < 70) begin
        nd = (m_q.size() < m_pw.size()) ? m_pw[m_q.size()] : int'($urandom_range(0, 9));
        n = 10'(1) << nd;
      end else if (r >= 70 && r < 85) n = 10'(1) << $urandom_range(0, 9);
      else if (r >= 92) n = (10'(1) << $urandom_range(0, 4)) | (10'(1) << $urandom_range(5, 9));
      press(s, h, n);
      exp = {m_mode == M_OPEN, m_mode == M_ALARM, m_mode == M_ENTER || m_mode == M_AUTH,
             m_mode == M_NEW, 4'(m_fail)};
      got = {open, alarm, mode_active, mode_set, fail_cnt};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random cyc %0d got %b exp %b", c, got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(1'b0, 1'b1, 10'h000); keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
    keys4(5, 6, 7, 8); press(1'b0, 1'b1, 10'h000);
    press(1'b0, 1'b1, 10'h000); keys4(5, 6, 7, 8); press(1'b0, 1'b1, 10'h000);
    checks++;
    if (mode_set !== 1'b1) begin errors++; $display("FAIL rstmid_in_new got %b exp 1", mode_set); end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({open, alarm, mode_active, mode_set, fail_cnt} !== 8'h00) begin
      errors++; $display("FAIL rstmid_outputs got %b exp 00000000", {open, alarm, mode_active, mode_set, fail_cnt});
    end
    @(negedge clk); n_rst = 1'b1; model_reset();
    press(1'b1, 1'b0, 10'h000); keys4(1, 2, 3, 4); press(1'b0, 1'b1, 10'h000);
    checks++;
    if (open !== 1'b1) begin errors++; $display("FAIL rstmid_pw_revert got %b exp 1", open); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_open();
    test_alarm();
    test_change_pw();
    test_short_priority();
    test_invalid_digit();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
